// File: rtl/img_wr_if.sv
// Bundles the convolver result stream and the result-memory write port.
// Pure wiring, no latency of its own.
// Backpressure: s_ready throttles the convolver, m_ready throttles the write port.
interface img_wr_if #(
  parameter int DIN_W  = 17,
  parameter int DOUT_W = 8,
  parameter int ADDR_W = 18
);
  logic              s_valid;
  logic              s_ready;
  logic [DIN_W-1:0]  s_data;
  logic              m_we;
  logic              m_ready;
  logic [ADDR_W-1:0] m_addr;
  logic [DOUT_W-1:0] m_wdata;

  // img_wr side: consumes results, issues memory writes
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_we, m_addr, m_wdata
  );

  // environment side: convolver source plus memory sink
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/img_wr.sv
// Scales 3x3 convolution sums (round, shift, saturate) and writes them to the result frame in compact raster order.
// Latency: an accepted sum reaches m_we on the next cycle at the earliest; 1 result/cycle sustained with m_ready high.
// Backpressure: 2-entry write buffer; s_ready (registered) drops when the buffer is full or the frame is fully accepted.
module img_wr #(
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  parameter int K      = 3,
  parameter int DIN_W  = 17,
  parameter int DOUT_W = 8,
  parameter int SHIFT  = 5,
  parameter int ADDR_W = 18
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     start,
  img_wr_if.slave  bus,
  output logic     busy,
  output logic     done
);

  localparam int OW = IMG_W - K + 1;
  localparam int OH = IMG_H - K + 1;
  // one extra bit so the accept counter can hold N itself
  localparam logic [ADDR_W:0] N = (ADDR_W + 1)'(OW * OH);
  localparam logic [DIN_W:0] RND = (DIN_W + 1)'(2 ** (SHIFT - 1));
  localparam int PW = DIN_W + 1 - SHIFT;
  localparam logic [PW-1:0] PMAX = PW'(2 ** DOUT_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state, state_d;
  logic [1:0]        buf_cnt, cnt_d;
  // Accept count doubles as the next write address: advancing col with a
  // wrap into row+1 is the same as +1 on row*OW+col in compact raster order.
  logic [ADDR_W:0]   acc_cnt, acc_d;
  logic              s_ready_q;
  logic              acc, pop, we;

  logic [ADDR_W-1:0] addr0, addr1;
  logic [DOUT_W-1:0] dat0, dat1;

  logic [DIN_W:0]    sum_r;
  logic [PW-1:0]     quo;
  logic [DOUT_W-1:0] pix;

  assign we  = (buf_cnt != 2'd0);
  assign acc = bus.s_valid & s_ready_q;
  assign pop = we & bus.m_ready;

  assign bus.s_ready = s_ready_q;
  assign bus.m_we    = we;
  assign bus.m_addr  = addr0;
  assign bus.m_wdata = dat0;

  // Round to nearest, normalise by the kernel weight sum, clamp to pixel range.
  always_comb begin
    sum_r = {1'b0, bus.s_data} + RND;
    quo   = sum_r[DIN_W:SHIFT];
    pix   = (quo > PMAX) ? '1 : quo[DOUT_W-1:0];
  end

  // Next buffer occupancy, accept count and state, shared by the registers below.
  always_comb begin
    cnt_d = buf_cnt;
    if (acc && !pop)
      cnt_d = buf_cnt + 2'd1;
    else if (!acc && pop)
      cnt_d = buf_cnt - 2'd1;

    acc_d = acc_cnt;
    if (acc)
      acc_d = acc_cnt + 1'b1;

    state_d = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          acc_d   = '0;
        end
      end
      RUN:     if (acc_d == N)    state_d = FLUSH;
      FLUSH:   if (cnt_d == 2'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM with registered status outputs; s_ready looks at next-cycle occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      state     <= state_d;
      busy      <= (state_d == RUN) || (state_d == FLUSH);
      done      <= (state_d == DONE);
      s_ready_q <= (state_d == RUN) && (cnt_d < 2'd2) && (acc_d < N);
    end
  end

  // Occupancy and accept counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_cnt <= '0;
      acc_cnt <= '0;
    end else begin
      buf_cnt <= cnt_d;
      acc_cnt <= acc_d;
    end
  end

  // Two-entry write buffer; entry 0 is the head and is never touched while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr0 <= '0;
      dat0  <= '0;
      addr1 <= '0;
      dat1  <= '0;
    end else begin
      case ({acc, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) begin
            addr0 <= acc_cnt[ADDR_W-1:0];
            dat0  <= pix;
          end else begin
            addr1 <= acc_cnt[ADDR_W-1:0];
            dat1  <= pix;
          end
        end
        2'b01: begin
          addr0 <= addr1;
          dat0  <= dat1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            addr0 <= acc_cnt[ADDR_W-1:0];
            dat0  <= pix;
          end else begin
            addr0 <= addr1;
            dat0  <= dat1;
            addr1 <= acc_cnt[ADDR_W-1:0];
            dat1  <= pix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_img_wr.sv
// Scoreboard bench for img_wr on a 5x5 image (3x3 output frame, 9 words).
// Stimulus issues sums; a negedge monitor predicts, pops and compares writes.
// Covers reset, arithmetic corners, backpressure, protocol misuse, random frames.
module tb_img_wr;
  localparam int IMG_W  = 5;
  localparam int IMG_H  = 5;
  localparam int K      = 3;
  localparam int DIN_W  = 17;
  localparam int DOUT_W = 8;
  localparam int SHIFT  = 5;
  localparam int ADDR_W = 18;
  localparam int N      = (IMG_W - K + 1) * (IMG_H - K + 1);
  localparam int DMAX   = (1 << DIN_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy, done;

  img_wr_if #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .ADDR_W(ADDR_W)) bus();

  img_wr #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .DIN_W(DIN_W),
    .DOUT_W(DOUT_W), .SHIFT(SHIFT), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  model_acc = 0;
  int  frame_writes = 0;
  int  done_cnt = 0;
  int  expect_done_at = -1;
  bit  frame_active = 1'b0;
  bit  prev_stall = 1'b0;
  int  prev_addr = 0;
  int  prev_data = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: round half up, divide by 2^SHIFT, clamp to the pixel maximum.
  function automatic int scale(input int d);
    int p;
    p = (d + (1 << (SHIFT - 1))) / (1 << SHIFT);
    return (p > (1 << DOUT_W) - 1) ? (1 << DOUT_W) - 1 : p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare writes, check hold under stall, done timing, predict accepts.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.m_we && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_write", 1, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 64'(bus.m_addr), 64'(e.addr));
          check("wr_data", 64'(bus.m_wdata), 64'(e.data));
        end
        frame_writes++;
        if (frame_writes == N) expect_done_at = cyc + 1;
      end
      if (prev_stall) begin
        check("stall_hold_we", 64'(bus.m_we), 1);
        check("stall_hold_addr", 64'(bus.m_addr), 64'(prev_addr));
        check("stall_hold_data", 64'(bus.m_wdata), 64'(prev_data));
      end
      prev_stall = bus.m_we && !bus.m_ready;
      prev_addr  = int'(bus.m_addr);
      prev_data  = int'(bus.m_wdata);
      if (done || cyc == expect_done_at) begin
        check("done_timing", 64'(done), 64'(cyc == expect_done_at));
        if (done) begin
          check("busy_at_done", 64'(busy), 0);
          check("frame_writes", 64'(frame_writes), 64'(N));
          done_cnt++;
          frame_active = 1'b0;
        end
        expect_done_at = -1;
      end
      if (bus.s_valid && bus.s_ready) begin
        check("accept_allowed", 64'(frame_active && model_acc < N), 1);
        exp_q.push_back('{model_acc, scale(int'(bus.s_data))});
        model_acc++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    if (!frame_active) begin
      frame_active = 1'b1;
      model_acc    = 0;
      frame_writes = 0;
    end
    step();
    start = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input int d);
    bit ok;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = DIN_W'(d);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.s_ready;
      step();
    end
    bus.s_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 200 && done_cnt == d0; i++) step();
    check("done_seen", 64'(done_cnt), 64'(d0 + 1));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_s_ready"}, 64'(bus.s_ready), 0);
    check({tag, "_m_we"}, 64'(bus.m_we), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_m_addr"}, 64'(bus.m_addr), 0);
    check({tag, "_m_wdata"}, 64'(bus.m_wdata), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int arith[9];
    int n_acc;
    bit a;
    int d0, dframe, acc_n;

    arith = '{15, 16, 48, 8175, 8176, 131071, 0, 31, 32};
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    step();
    rst = 1'b1;
    step();

    // straight stream: data i*32 -> pixel i at address i
    do_start();
    for (int i = 0; i < N; i++) send(i * 32);
    wait_done();
    @(negedge clk);
    check("busy_after_done", 64'(busy), 0);
    step();

    // rounding and saturation corners
    do_start();
    foreach (arith[i]) send(arith[i]);
    wait_done();

    // write backpressure: buffer absorbs two, then s_ready drops
    do_start();
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = DIN_W'($urandom_range(DMAX, 0));
    n_acc = 0;
    repeat (10) begin
      @(negedge clk);
      a = bus.s_ready;
      step();
      if (a) begin
        n_acc++;
        bus.s_data = DIN_W'($urandom_range(DMAX, 0));
      end
    end
    @(negedge clk);
    check("bp_accepts", 64'(n_acc), 2);
    check("bp_s_ready", 64'(bus.s_ready), 0);
    step();
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 2; i < N; i++) send(int'($urandom_range(DMAX, 0)));
    wait_done();

    // start pulses mid-frame are ignored
    do_start();
    for (int i = 0; i < N; i++) begin
      if (i == 3 || i == 6) pulse_start();
      send(int'($urandom_range(DMAX, 0)));
    end
    wait_done();

    // valid offered while idle is never accepted
    bus.s_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("idle_s_ready", 64'(bus.s_ready), 0);
      check("idle_m_we", 64'(bus.m_we), 0);
      step();
    end
    bus.s_valid = 1'b0;

    // reset mid-frame with a full buffer
    do_start();
    bus.m_ready = 1'b0;
    send(100);
    send(200);
    rst = 1'b0;
    exp_q.delete();
    frame_active   = 1'b0;
    expect_done_at = -1;
    prev_stall     = 1'b0;
    @(negedge clk);
    check_outputs_zero("midrst");
    step();
    rst = 1'b1;
    bus.m_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("post_rst_no_we", 64'(bus.m_we), 0);
      step();
    end
    do_start();
    for (int i = 0; i < N; i++) send(int'($urandom_range(DMAX, 0)));
    wait_done();

    // three back-to-back frames with random valid and ready
    d0 = done_cnt;
    for (int f = 0; f < 3; f++) begin
      dframe = done_cnt;
      do_start();
      acc_n = 0;
      for (int i = 0; i < 600 && done_cnt == dframe; i++) begin
        if (!bus.s_valid && acc_n < N) begin
          bus.s_valid = 1'($urandom_range(1, 0));
          bus.s_data  = DIN_W'($urandom_range(DMAX, 0));
        end
        bus.m_ready = ($urandom_range(3, 0) != 0);
        @(negedge clk);
        a = bus.s_valid && bus.s_ready;
        step();
        if (a) begin
          acc_n++;
          bus.s_valid = 1'b0;
        end
      end
      check("rand_frame_done", 64'(done_cnt), 64'(dframe + 1));
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    check("rand_dones", 64'(done_cnt - d0), 3);
    repeat (3) step();
    check("scoreboard_empty", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
